// File: rtl/burst_gate_array.sv
// Multi-channel hysteretic burst gate for stochastic bitstreams.
// Each channel holds its mode. It flips only when the sliding window
// {history, IN} has enough bits of the opposite value. Each channel also
// keeps a saturating count of how many times it has switched.

module bga_lane #(
  parameter int MEMSIZE = 6,
  parameter int CNTW    = 3,
  parameter int SWCW    = 8
) (
  input  logic            CLK,
  input  logic            INIT,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic            in_i,
  input  logic            init_state_i,
  input  logic [CNTW-1:0] th_up_i,
  input  logic [CNTW-1:0] th_dn_i,
  output logic            mode_o,
  output logic            sw_o,
  output logic [SWCW-1:0] swcnt_o
);
  localparam int WIN = MEMSIZE + 1;

  logic               mode_q, mode_d;
  logic               sw_q, sw_d;
  logic [MEMSIZE-1:0] mem_q, mem_d;
  logic [SWCW-1:0]    cnt_q, cnt_d;
  logic [CNTW-1:0]    ones, zeros, th_up_eff, th_dn_eff;
  logic               rise, fall;

  // Window popcount. CNTW is wide enough to hold WIN, so no overflow.
  always_comb begin
    ones = '0;
    for (int i = 0; i < MEMSIZE; i++) ones = ones + CNTW'(mem_q[i]);
    ones  = ones + CNTW'(in_i);
    zeros = CNTW'(WIN) - ones;
  end

  // A threshold of 0 means 1. A threshold above WIN can never be met,
  // so that direction never switches and needs no special case.
  always_comb begin
    th_up_eff = (th_up_i == '0) ? CNTW'(1) : th_up_i;
    th_dn_eff = (th_dn_i == '0) ? CNTW'(1) : th_dn_i;
    rise = ~mode_q &  in_i & (ones  >= th_up_eff);
    fall =  mode_q & ~in_i & (zeros >= th_dn_eff);
  end

  // Next state. The counter clear is honoured even while the lane is disabled.
  always_comb begin
    mode_d = mode_q;
    mem_d  = mem_q;
    sw_d   = 1'b0;
    cnt_d  = cnt_q;
    if (en_i) begin
      sw_d   = rise | fall;
      mode_d = mode_q ^ sw_d;
      mem_d  = {mem_q[MEMSIZE-2:0], in_i};
      if (sw_d && (cnt_q != {SWCW{1'b1}})) cnt_d = cnt_q + SWCW'(1);
    end
    if (clr_i) cnt_d = '0;
  end

  // State registers. INIT is asynchronous and loads the channel init bit everywhere.
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      mode_q <= init_state_i;
      mem_q  <= {MEMSIZE{init_state_i}};
      sw_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      mode_q <= mode_d;
      mem_q  <= mem_d;
      sw_q   <= sw_d;
      cnt_q  <= cnt_d;
    end
  end

  assign mode_o  = mode_q;
  assign sw_o    = sw_q;
  assign swcnt_o = cnt_q;
endmodule

module burst_gate_array #(
  parameter int CHANNELS = 4,
  parameter int MEMSIZE  = 6,
  parameter int CNTW     = 3,
  parameter int SWCW     = 8
) (
  input  logic                     CLK,
  input  logic                     INIT,
  input  logic                     EN,
  input  logic                     CLR_CNT,
  input  logic [CHANNELS-1:0]      IN,
  input  logic [CHANNELS-1:0]      INIT_STATE,
  input  logic [CNTW-1:0]          TH_UP,
  input  logic [CNTW-1:0]          TH_DN,
  output logic [CHANNELS-1:0]      OUT,
  output logic [CHANNELS-1:0]      SW,
  output logic [CHANNELS*SWCW-1:0] SWCNT
);
  logic [CHANNELS-1:0][SWCW-1:0] swcnt;

  // One independent lane per channel. Thresholds and controls are shared.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    bga_lane #(.MEMSIZE(MEMSIZE), .CNTW(CNTW), .SWCW(SWCW)) u_lane (
      .CLK          (CLK),
      .INIT         (INIT),
      .en_i         (EN),
      .clr_i        (CLR_CNT),
      .in_i         (IN[c]),
      .init_state_i (INIT_STATE[c]),
      .th_up_i      (TH_UP),
      .th_dn_i      (TH_DN),
      .mode_o       (OUT[c]),
      .sw_o         (SW[c]),
      .swcnt_o      (swcnt[c])
    );
  end

  assign SWCNT = swcnt;
endmodule

// File: tb/tb_burst_gate_array.sv
// Randomized and directed bench for burst_gate_array. It checks the DUT
// against a queue-based window model.
module tb_burst_gate_array;
  localparam int CH   = 4;
  localparam int MS   = 6;
  localparam int CW   = 4;
  localparam int SWCW = 4;
  localparam int WIN  = MS + 1;
  localparam int CMAX = (1 << SWCW) - 1;

  logic              CLK = 1'b0;
  logic              INIT, EN, CLR_CNT;
  logic [CH-1:0]     IN, INIT_STATE, OUT, SW;
  logic [CW-1:0]     TH_UP, TH_DN;
  logic [CH*SWCW-1:0] SWCNT;

  burst_gate_array #(.CHANNELS(CH), .MEMSIZE(MS), .CNTW(CW), .SWCW(SWCW)) dut (
    .CLK(CLK), .INIT(INIT), .EN(EN), .CLR_CNT(CLR_CNT), .IN(IN),
    .INIT_STATE(INIT_STATE), .TH_UP(TH_UP), .TH_DN(TH_DN),
    .OUT(OUT), .SW(SW), .SWCNT(SWCNT)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: the last MS input bits per channel (oldest first), plus mode, pulse and count.
  bit m_hist[CH][$];
  int m_mode[CH];
  int m_sw[CH];
  int m_cnt[CH];

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_init();
    for (int c = 0; c < CH; c++) begin
      m_hist[c].delete();
      for (int i = 0; i < MS; i++) m_hist[c].push_back(INIT_STATE[c]);
      m_mode[c] = int'(INIT_STATE[c]);
      m_sw[c]   = 0;
      m_cnt[c]  = 0;
    end
  endtask

  task automatic model_edge();
    int ones, zeros, up, dn;
    bit flip;
    up = (TH_UP == 0) ? 1 : int'(TH_UP);
    dn = (TH_DN == 0) ? 1 : int'(TH_DN);
    for (int c = 0; c < CH; c++) begin
      m_sw[c] = 0;
      if (EN) begin
        ones = int'(IN[c]);
        for (int i = 0; i < MS; i++) ones += int'(m_hist[c][i]);
        zeros = WIN - ones;
        flip = (m_mode[c] == 0 && IN[c] && ones >= up) ||
               (m_mode[c] == 1 && !IN[c] && zeros >= dn);
        if (flip) begin
          m_mode[c] = 1 - m_mode[c];
          m_sw[c]   = 1;
          if (m_cnt[c] < CMAX) m_cnt[c]++;
        end
        void'(m_hist[c].pop_front());
        m_hist[c].push_back(IN[c]);
      end
      if (CLR_CNT) m_cnt[c] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < CH; c++) begin
      chk({tag, "_out"},   int'(OUT[c]), m_mode[c]);
      chk({tag, "_sw"},    int'(SW[c]),  m_sw[c]);
      chk({tag, "_swcnt"}, int'(SWCNT[c*SWCW +: SWCW]), m_cnt[c]);
    end
  endtask

  // Apply one set of inputs across one rising edge, then compare.
  task automatic step(input logic [CH-1:0] in_v, input logic en_v, input logic clr_v);
    IN = in_v; EN = en_v; CLR_CNT = clr_v;
    model_edge();
    @(posedge CLK);
    #1;
    check_all("step");
  endtask

  // Assert INIT between edges, hold it across one edge, then release it between edges.
  task automatic do_init(input logic [CH-1:0] st);
    #2;
    INIT_STATE = st;
    INIT = 1'b1;
    #1;
    model_init();
    chk("init_out_now", int'(OUT), int'(st));
    check_all("init");
    @(posedge CLK);
    #1;
    check_all("init_held");
    INIT = 1'b0;
  endtask

  initial begin
    INIT = 1'b1; EN = 1'b1; CLR_CNT = 1'b0; IN = '0; INIT_STATE = '0;
    TH_UP = CW'(WIN); TH_DN = CW'(WIN);

    // Legacy all-N: six ones then a zero must not rise; seven ones must rise.
    do_init('0);
    repeat (6) step(4'b0001, 1'b1, 1'b0);
    chk("legacy_no_rise6", int'(OUT[0]), 0);
    step(4'b0000, 1'b1, 1'b0);
    repeat (6) step(4'b0001, 1'b1, 1'b0);
    chk("legacy_no_rise_yet", int'(OUT[0]), 0);
    step(4'b0001, 1'b1, 1'b0);
    chk("legacy_rise", int'(OUT[0]), 1);
    chk("legacy_sw", int'(SW[0]), 1);
    chk("legacy_cnt", int'(SWCNT[SWCW-1:0]), 1);
    step(4'b0001, 1'b1, 1'b0);
    chk("legacy_sw_once", int'(SW[0]), 0);

    // 3-of-7 rise on channel 1 with the input pattern 1,0,1,0,1.
    do_init('0);
    TH_UP = 4'd3;
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    chk("kofn_not_early", int'(OUT[1]), 0);
    step(4'b0010, 1'b1, 1'b0);
    chk("kofn_rise", int'(OUT[1]), 1);

    // 4-of-7 fall, first straight and then with one interleaved 1.
    TH_DN = 4'd4; TH_UP = 4'd7;
    do_init('1);
    repeat (3) step(4'b0000, 1'b1, 1'b0);
    chk("fall_not_early", int'(OUT), 4'hF);
    step(4'b0000, 1'b1, 1'b0);
    chk("fall", int'(OUT), 0);
    do_init('1);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    chk("fall_delayed", int'(OUT), 4'hF);
    step(4'b0000, 1'b1, 1'b0);
    chk("fall_after_gap", int'(OUT), 0);

    // Enable low: toggling input must change nothing.
    repeat (10) step(CH'($urandom), 1'b0, 1'b0);
    chk("en_hold", int'(OUT), 0);

    // A threshold larger than the window never rises; a threshold of 0 acts as 1.
    TH_UP = 4'd9;
    repeat (10) step('1, 1'b1, 1'b0);
    chk("never_rise", int'(OUT), 0);
    TH_UP = 4'd0;
    step('1, 1'b1, 1'b0);
    chk("th0_rise", int'(OUT), 4'hF);

    // Saturation, then a clear on the same edge as a switch.
    TH_UP = 4'd1; TH_DN = 4'd0;
    for (int i = 0; i < 20; i++) step((i % 2) ? '1 : '0, 1'b1, 1'b0);
    chk("sat_cnt", int'(SWCNT), 16'hFFFF);
    step('0, 1'b1, 1'b1);
    chk("clr_wins_cnt", int'(SWCNT), 0);
    chk("clr_sw_pulse", int'(SW), 4'hF);

    // INIT in the middle of a stream.
    repeat (3) step(CH'($urandom), 1'b1, 1'b0);
    do_init(4'b1010);
    step(4'b0000, 1'b1, 1'b0);

    // Random soak.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) TH_UP = CW'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) TH_DN = CW'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) do_init(CH'($urandom));
      step(CH'($urandom), ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/burst_gate_array.md
Name: burst_gate_array

Overview:
- Multi-channel, threshold-programmable successor to the single-channel burst gate operator in the stochastic NN datapath.
- Each channel is a hysteretic filter on a stochastic bitstream:
  - The output holds its current mode.
  - It switches only when enough opposite-valued bits appear in a sliding history window.
- Adds runtime rise/fall thresholds (k-of-N instead of all-N), a global enable, switch pulses and per-channel saturating switch counters for activity monitoring.

Parameters:
- CHANNELS, 4, number of independent gate channels.
- MEMSIZE, 6, history shift-register depth per channel (≥2); the window is MEMSIZE+1 bits (history plus current IN).
- CNTW, 3, width of threshold ports; must satisfy 2^CNTW > MEMSIZE+1.
- SWCW, 8, width of each per-channel switch counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- INIT  in  1  reset, asynchronous, active-high; loads INIT_STATE into all channel state.
- EN  in  1  global advance enable; low = all state held.
- CLR_CNT  in  1  synchronous clear of all switch counters.
- IN  in  CHANNELS  stochastic input bit per channel.
- INIT_STATE  in  CHANNELS  per-channel mode/history value loaded during INIT.
- TH_UP  in  CNTW  ones count in window required to switch mode 0→1.
- TH_DN  in  CNTW  zeros count in window required to switch mode 1→0.
- OUT  out  CHANNELS  gated output bit per channel (equals channel mode).
- SW  out  CHANNELS  one-cycle pulse, high in the cycle after a channel changed mode.
- SWCNT  out  CHANNELS*SWCW  per-channel saturating mode-switch count; channel c at bits [c*SWCW +: SWCW].

Behaviour:
- Per-channel state: MODE (1b), MEM (MEMSIZE b), SWCNT (SWCW b). OUT = MODE and is registered, with no combinational path from IN.
- INIT high (async, dominates everything):
  - MODE[c] = INIT_STATE[c]; every MEM bit of channel c = INIT_STATE[c].
  - SW = 0; SWCNT = 0.
  - Held while INIT is high; normal operation resumes on the first CLK edge after deassertion.
- EN low on an edge:
  - MODE, MEM and SWCNT hold.
  - SW = 0.
  - CLR_CNT is still honoured.
- EN high, per channel, evaluated on the pre-edge MEM and current IN:
  - window W = {MEM, IN} (MEMSIZE+1 bits); ones = popcount(W); zeros = MEMSIZE+1-ones.
  - Effective threshold: TH_x = 0 is treated as 1. TH_x > MEMSIZE+1 means that direction never switches.
  - MODE=0, IN=1, ones ≥ TH_UP → MODE=1, SW=1.
  - MODE=1, IN=0, zeros ≥ TH_DN → MODE=0, SW=1.
  - Otherwise MODE holds and SW=0. An input equal to MODE never switches.
  - MEM ← {MEM[MEMSIZE-2:0], IN} on every enabled edge, whether or not a switch occurs.
- Latency: the IN bit sampled at edge k affects OUT and SW after edge k (1 cycle).
- Legacy equivalence: TH_UP = TH_DN = MEMSIZE+1 requires MEMSIZE+1 consecutive opposite bits, matching the original gate's all-ones/all-zeros rule.
- SWCNT:
  - Increments by 1 on each switch and saturates at 2^SWCW-1 (no wrap).
  - CLR_CNT on an edge forces it to 0.
  - If CLR_CNT and a switch occur on the same edge, the result is 0; the clear wins. SW still pulses.
- Threshold ports may change at any time and take effect on the next edge. Channels are fully independent.
- INIT asserted mid-stream discards history immediately, with no partial update on a coincident CLK edge.

Test Plan:
- Legacy mode: MEMSIZE=6, TH_UP=TH_DN=7, INIT_STATE=0, IN[0] = 1 for 6 cycles then 0 → OUT[0] stays 0, MEM resets. Then 7 consecutive 1s → OUT[0]=1 after the 7th edge, SW[0] pulses once, SWCNT[0]=1.
- k-of-N rise: TH_UP=3, MODE=0, IN[1] = 1,0,1,0,1 from an all-zero history → OUT[1] rises after the 5th edge (3 ones in the window), not earlier.
- Hysteresis fall: TH_DN=4, MODE=1, history all 1s, IN = 0,0,0,0 → OUT falls after the 4th edge. An interleaved 1 delays the fall by the corresponding window count.
- Enable/never-switch: EN=0 for 10 cycles with toggling IN → OUT, MEM and SWCNT unchanged, SW=0. TH_UP=7 with MEMSIZE=4 (value > window) → channel never rises.
- Counter: SWCW=2, force 5 switches → SWCNT saturates at 3. CLR_CNT on the same edge as a switch → SWCNT=0 and SW=1.
- Async INIT mid-stream: assert INIT between edges with INIT_STATE=4'b1010 → OUT=1010 immediately, SW=0, SWCNT=0, all MEM bits per channel = INIT_STATE bit; the next edge after release evaluates from that history.
